mac_operand_splitter: RTL and testbench
=======================================

# mac_operand_splitter

Input-side counterpart of the MAC result combiner. Accepts one wide operand transaction per cycle, slices it into `MAC_MIN_WIDTH lanes according to the single/dual/quad configuration, and presents per-lane multiplicand/multiplier pairs plus slice signedness to the four MAC lanes. The combiner reassembles the lane partials using the same lane-to-slice mapping. A 2-entry skid buffer decouples the upstream valid/ready from the lane-side valid/ready, sustaining one transaction per cycle.

## Interface
- W = `MAC_MIN_WIDTH (derived, not overridable): lane slice width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  global enable; 0 freezes all state and blocks both handshakes
- in_valid  in  1  upstream transaction valid
- in_ready  out  1  splitter can accept; en & (count < 2)
- cfg  in  2  `MAC_DUAL, `MAC_QUAD, any other value = single; sampled with the transaction
- a  in  4W  multiplicand field
- b  in  4W  multiplier field
- a_signed, b_signed  in  1  operand signedness
- out_valid  out  1  lane operands valid (count != 0)
- out_ready  in  1  lanes consume
- out_cfg  out  2  cfg of head entry, normalized (non-DUAL/QUAD → 2'b00)
- lane_a0..lane_a3  out  W  per-lane multiplicand slice
- lane_b0..lane_b3  out  W  per-lane multiplier slice
- lane_a_signed  out  4  per-lane multiplicand slice signedness, bit i = lane i
- lane_b_signed  out  4  per-lane multiplier signedness
- xfer_count  out  16  completed output handshakes, wraps at 2^16

## Operation
- Slicing is done before storage; buffer entries hold lane-mapped fields plus out_cfg.
- Single: lane i gets a[iW+:W], b[iW+:W]; lane_a_signed = {4{a_signed}}; lane_b_signed = {4{b_signed}}.
- Dual: two 2W×W products. Pair 0: lane0 = a[W-1:0], lane1 = a[2W-1:W], both b = b[W-1:0]. Pair 1 (swapped order to match combiner): lane3 = a[3W-1:2W] (low), lane2 = a[4W-1:3W] (high), both b = b[3W-1:2W]. lane_a_signed = {1'b0, a_signed, a_signed, 1'b0} (bits 3..0: lanes 2 and 1 carry the MSB slices); lane_b_signed = {4{b_signed}}.
- Quad: one 4W×W product. Lane i gets a[iW+:W]; all lanes b = b[W-1:0]; lane_a_signed = {a_signed, 3'b000}; lane_b_signed = {4{b_signed}}.
- Unused b bits are ignored; no error signalling.
- Buffer: 2-entry FIFO, count ∈ {0,1,2}, strict in-order. Head entry drives all lane outputs.
- push = en & in_valid & in_ready; pop = en & out_valid & out_ready.
- count' = count + push − pop. Push at count 1 with simultaneous pop: new entry becomes head on next cycle.
- xfer_count increments on every pop, wraps 16'hFFFF → 0.
- en = 0: count, entries, xfer_count hold; in_ready = 0; out_valid still reflects count, but no pop occurs.

## Timing
- Reset (rst_n low, asynchronous): count = 0, both entries zeroed, out_valid = 0, in_ready = 0 while rst_n low, then en-gated; all lane outputs, lane_*_signed, out_cfg = 0; xfer_count = 0.
- Latency: transaction pushed at edge N appears on lane outputs with out_valid = 1 after edge N (visible in cycle N+1) when buffer was empty.
- Throughput: 1 transaction/cycle while out_ready stays high.
- in_ready depends only on registered count and en; no combinational path from out_ready to in_ready.
- Full (count = 2): in_ready = 0; a pop that cycle frees a slot, in_ready rises next cycle.
- Empty: out_valid = 0; lane outputs hold last popped contents (not required to be zero).
- Reset asserted mid-transfer discards all buffered entries; no partial output after release.

## Test plan
- W=8, quad: a=32'h12345678, b=32'h00000003, a_signed=1, out_ready=1 → next cycle lane_a0..3 = 78,56,34,12; all lane_b = 03; lane_a_signed = 4'b1000; out_cfg = `MAC_QUAD.
- Dual: a=32'hAABBCCDD, b=32'h00110022, a_signed=1 → lane0=DD, lane1=CC, lane_b0/1=22; lane3=BB, lane2=AA, lane_b2/3=11; lane_a_signed = 4'b0110.
- Single, cfg=2'b11 (unused): a=32'h01020304, b=32'h05060708 → lane i = bytes 04,03,02,01 / 08,07,06,05; out_cfg = 00.
- Backpressure: out_ready=0, push 3 back-to-back → 2 accepted, in_ready = 0 on third; release out_ready → outputs in order, xfer_count = 2, in_ready returns one cycle after first pop.
- en=0 for 3 cycles with in_valid/out_ready high → no push, no pop, count and xfer_count unchanged; resume → normal flow.
- Assert rst_n low with count = 2 mid-cycle → out_valid, lane outputs, xfer_count go 0 immediately; after release, first new push appears with latency 1.

Source files
------------

// File: rtl/mac_operand_splitter.sv
// Wide-operand splitter for the MAC lanes: slices a/b per single/dual/quad mode
// and buffers the lane-mapped operands in a 2-entry skid buffer.
`ifndef MAC_MIN_WIDTH
`define MAC_MIN_WIDTH 8
`endif
`ifndef MAC_DUAL
`define MAC_DUAL 2'b01
`endif
`ifndef MAC_QUAD
`define MAC_QUAD 2'b10
`endif

module mac_operand_splitter (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  cfg,
  input  logic [4*`MAC_MIN_WIDTH-1:0] a,
  input  logic [4*`MAC_MIN_WIDTH-1:0] b,
  input  logic                        a_signed,
  input  logic                        b_signed,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [1:0]                  out_cfg,
  output logic [`MAC_MIN_WIDTH-1:0]   lane_a0,
  output logic [`MAC_MIN_WIDTH-1:0]   lane_a1,
  output logic [`MAC_MIN_WIDTH-1:0]   lane_a2,
  output logic [`MAC_MIN_WIDTH-1:0]   lane_a3,
  output logic [`MAC_MIN_WIDTH-1:0]   lane_b0,
  output logic [`MAC_MIN_WIDTH-1:0]   lane_b1,
  output logic [`MAC_MIN_WIDTH-1:0]   lane_b2,
  output logic [`MAC_MIN_WIDTH-1:0]   lane_b3,
  output logic [3:0]                  lane_a_signed,
  output logic [3:0]                  lane_b_signed,
  output logic [15:0]                 xfer_count
);

  localparam int W = `MAC_MIN_WIDTH;

  typedef struct packed {
    logic [1:0]          cfg;
    logic [3:0]          a_sgn;
    logic [3:0]          b_sgn;
    logic [3:0][W-1:0]   la;
    logic [3:0][W-1:0]   lb;
  } entry_t;

  // Lane mapping must stay in lockstep with the result combiner.
  function automatic entry_t slice_fn(input logic [1:0] c, input logic [4*W-1:0] av,
                                      input logic [4*W-1:0] bv, input logic asg,
                                      input logic bsg);
    entry_t e;
    e = '0;
    case (c)
      `MAC_DUAL: begin
        e.cfg   = `MAC_DUAL;
        e.la[0] = av[W-1:0];
        e.la[1] = av[2*W-1:W];
        e.la[3] = av[3*W-1:2*W];
        e.la[2] = av[4*W-1:3*W];
        e.lb[0] = bv[W-1:0];
        e.lb[1] = bv[W-1:0];
        e.lb[2] = bv[3*W-1:2*W];
        e.lb[3] = bv[3*W-1:2*W];
        e.a_sgn = {1'b0, asg, asg, 1'b0};
        e.b_sgn = {4{bsg}};
      end
      `MAC_QUAD: begin
        e.cfg   = `MAC_QUAD;
        e.la    = av;
        e.lb    = {4{bv[W-1:0]}};
        e.a_sgn = {asg, 3'b000};
        e.b_sgn = {4{bsg}};
      end
      default: begin
        e.cfg   = 2'b00;
        e.la    = av;
        e.lb    = bv;
        e.a_sgn = {4{asg}};
        e.b_sgn = {4{bsg}};
      end
    endcase
    return e;
  endfunction

  entry_t      head_r, tail_r, head_nxt_s, tail_nxt_s, new_s;
  logic [1:0]  count_r, count_nxt_s;
  logic [15:0] xfer_r;
  logic        push_s, pop_s;

  assign in_ready  = rst_n & en & (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign push_s    = en & in_valid & in_ready;
  assign pop_s     = en & out_valid & out_ready;
  assign new_s     = slice_fn(cfg, a, b, a_signed, b_signed);

  // Skid-buffer next state: head always drives the lanes, tail only holds the second entry.
  always_comb begin
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = 2'(count_r + {1'b0, push_s} - {1'b0, pop_s});
    if (pop_s) begin
      if (count_r == 2'd2) begin
        head_nxt_s = tail_r;
      end else if (push_s) begin
        head_nxt_s = new_s;
      end else begin
        head_nxt_s = head_r;
      end
    end else if (push_s) begin
      if (count_r == 2'd0) begin
        head_nxt_s = new_s;
      end else begin
        tail_nxt_s = new_s;
      end
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Buffer state and transfer counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= 2'd0;
      xfer_r  <= 16'd0;
    end else begin
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
      if (pop_s) begin
        xfer_r <= xfer_r + 16'd1;
      end
    end
  end

  assign out_cfg       = head_r.cfg;
  assign lane_a0       = head_r.la[0];
  assign lane_a1       = head_r.la[1];
  assign lane_a2       = head_r.la[2];
  assign lane_a3       = head_r.la[3];
  assign lane_b0       = head_r.lb[0];
  assign lane_b1       = head_r.lb[1];
  assign lane_b2       = head_r.lb[2];
  assign lane_b3       = head_r.lb[3];
  assign lane_a_signed = head_r.a_sgn;
  assign lane_b_signed = head_r.b_sgn;
  assign xfer_count    = xfer_r;

endmodule

// File: tb/tb_mac_operand_splitter.sv
// Directed self-checking bench for mac_operand_splitter (W = 8).
`ifndef MAC_MIN_WIDTH
`define MAC_MIN_WIDTH 8
`endif
`ifndef MAC_DUAL
`define MAC_DUAL 2'b01
`endif
`ifndef MAC_QUAD
`define MAC_QUAD 2'b10
`endif

module tb_mac_operand_splitter;

  logic        clk, rst_n, en, in_valid, in_ready, a_signed, b_signed;
  logic        out_valid, out_ready;
  logic [1:0]  cfg, out_cfg;
  logic [31:0] a, b;
  logic [7:0]  lane_a0, lane_a1, lane_a2, lane_a3;
  logic [7:0]  lane_b0, lane_b1, lane_b2, lane_b3;
  logic [3:0]  lane_a_signed, lane_b_signed;
  logic [15:0] xfer_count;
  int          n_checks, n_pass;

  mac_operand_splitter dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .cfg(cfg), .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_cfg(out_cfg),
    .lane_a0(lane_a0), .lane_a1(lane_a1), .lane_a2(lane_a2), .lane_a3(lane_a3),
    .lane_b0(lane_b0), .lane_b1(lane_b1), .lane_b2(lane_b2), .lane_b3(lane_b3),
    .lane_a_signed(lane_a_signed), .lane_b_signed(lane_b_signed),
    .xfer_count(xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] av,
                       input logic [31:0] bv, input logic asg, input logic bsg);
    in_valid = v; cfg = c; a = av; b = bv; a_signed = asg; b_signed = bsg;
  endtask

  function automatic logic [31:0] la_s();
    return {lane_a3, lane_a2, lane_a1, lane_a0};
  endfunction

  function automatic logic [31:0] lb_s();
    return {lane_b3, lane_b2, lane_b1, lane_b0};
  endfunction

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; en = 1'b1; out_ready = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_lanes_a", la_s(), 32'h0);
    check_eq("rst_xfer", {16'd0, xfer_count}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // back-to-back quad, dual, single with out_ready high
    out_ready = 1'b1;
    drive(1'b1, `MAC_QUAD, 32'h12345678, 32'h00000003, 1'b1, 1'b0);
    step();
    check_eq("quad_valid", {31'd0, out_valid}, 32'd1);
    check_eq("quad_la", la_s(), 32'h12345678);
    check_eq("quad_lb", lb_s(), 32'h03030303);
    check_eq("quad_as", {28'd0, lane_a_signed}, 32'h8);
    check_eq("quad_bs", {28'd0, lane_b_signed}, 32'h0);
    check_eq("quad_cfg", {30'd0, out_cfg}, {30'd0, `MAC_QUAD});
    drive(1'b1, `MAC_DUAL, 32'hAABBCCDD, 32'h00110022, 1'b1, 1'b1);
    step();
    check_eq("dual_la", la_s(), 32'hBBAACCDD);
    check_eq("dual_lb", lb_s(), 32'h11112222);
    check_eq("dual_as", {28'd0, lane_a_signed}, 32'h6);
    check_eq("dual_bs", {28'd0, lane_b_signed}, 32'hF);
    check_eq("dual_cfg", {30'd0, out_cfg}, {30'd0, `MAC_DUAL});
    check_eq("dual_xfer", {16'd0, xfer_count}, 32'd1);
    drive(1'b1, 2'b11, 32'h01020304, 32'h05060708, 1'b0, 1'b1);
    step();
    check_eq("single_la", la_s(), 32'h01020304);
    check_eq("single_lb", lb_s(), 32'h05060708);
    check_eq("single_as", {28'd0, lane_a_signed}, 32'h0);
    check_eq("single_bs", {28'd0, lane_b_signed}, 32'hF);
    check_eq("single_cfg", {30'd0, out_cfg}, 32'd0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    check_eq("drain_valid", {31'd0, out_valid}, 32'd0);
    check_eq("drain_xfer", {16'd0, xfer_count}, 32'd3);

    // backpressure: three pushes, only two accepted
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h000000A1, 32'h0, 1'b0, 1'b0);
    step();
    check_eq("bp_ready1", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 2'b00, 32'h000000A2, 32'h0, 1'b0, 1'b0);
    step();
    check_eq("bp_full_ready", {31'd0, in_ready}, 32'd0);
    check_eq("bp_head1", la_s(), 32'h000000A1);
    drive(1'b1, 2'b00, 32'h000000A3, 32'h0, 1'b0, 1'b0);
    step();
    check_eq("bp_third_ready", {31'd0, in_ready}, 32'd0);
    check_eq("bp_head_hold", la_s(), 32'h000000A1);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    check_eq("bp_head2", la_s(), 32'h000000A2);
    check_eq("bp_ready_back", {31'd0, in_ready}, 32'd1);
    check_eq("bp_xfer1", {16'd0, xfer_count}, 32'd4);
    step();
    check_eq("bp_empty", {31'd0, out_valid}, 32'd0);
    check_eq("bp_xfer2", {16'd0, xfer_count}, 32'd5);

    // enable freeze
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h000000B4, 32'h0, 1'b0, 1'b0);
    step();
    en = 1'b0; out_ready = 1'b1;
    drive(1'b1, 2'b00, 32'h000000B5, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("en0_ready", {31'd0, in_ready}, 32'd0);
      check_eq("en0_valid", {31'd0, out_valid}, 32'd1);
      check_eq("en0_head", la_s(), 32'h000000B4);
      check_eq("en0_xfer", {16'd0, xfer_count}, 32'd5);
    end
    en = 1'b1;
    step();
    check_eq("resume_head", la_s(), 32'h000000B5);
    check_eq("resume_xfer", {16'd0, xfer_count}, 32'd6);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    check_eq("resume_xfer2", {16'd0, xfer_count}, 32'd7);

    // reset mid-cycle with a full buffer
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h000000C6, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'b00, 32'h000000C7, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mrst_lanes", la_s(), 32'h0);
    check_eq("mrst_xfer", {16'd0, xfer_count}, 32'd0);
    check_eq("mrst_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 32'h000000D8, 32'h0, 1'b0, 1'b0);
    step();
    check_eq("post_mrst_valid", {31'd0, out_valid}, 32'd1);
    check_eq("post_mrst_head", la_s(), 32'h000000D8);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    check_eq("post_mrst_xfer", {16'd0, xfer_count}, 32'd1);
    check_eq("post_mrst_empty", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
